// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and helpers for the BTB branch predictor: entry layout, PC field
// extraction and saturating direction-counter arithmetic.
package bp_pkg;

  // Storage is laid out at these maximum widths; upper bits stay zero for narrower configs.
  localparam int unsigned MAX_PC_W  = 64;
  localparam int unsigned MAX_TAG_W = 32;
  localparam int unsigned MAX_CTR_W = 8;

  typedef logic [MAX_PC_W-1:0]  pc_t;
  typedef logic [MAX_TAG_W-1:0] tag_t;
  typedef logic [MAX_CTR_W-1:0] ctr_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
    pc_t  target;
    ctr_t ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_max(int unsigned w);
    return MAX_CTR_W'((32'd1 << w) - 32'd1);
  endfunction

  // Weakly taken / weakly not taken.
  function automatic ctr_t ctr_wt(int unsigned w);
    return MAX_CTR_W'(32'd1 << (w - 1));
  endfunction

  function automatic ctr_t ctr_wnt(int unsigned w);
    return ctr_wt(w) - MAX_CTR_W'(1);
  endfunction

  function automatic logic ctr_msb(ctr_t ctr, int unsigned w);
    return ((ctr >> (w - 1)) & MAX_CTR_W'(1)) != '0;
  endfunction

  function automatic ctr_t ctr_next(ctr_t ctr, logic taken, int unsigned w);
    if (taken) return (ctr == ctr_max(w)) ? ctr : ctr + MAX_CTR_W'(1);
    return (ctr == '0) ? ctr : ctr - MAX_CTR_W'(1);
  endfunction

  function automatic int unsigned pc_idx(pc_t pc, int unsigned idx_w);
    pc_t mask = (pc_t'(1) << idx_w) - pc_t'(1);
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic tag_t pc_tag(pc_t pc, int unsigned idx_w, int unsigned tag_w);
    pc_t mask = (pc_t'(1) << tag_w) - pc_t'(1);
    return MAX_TAG_W'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, EX training/mispredict and perf-counter signals of the predictor.
interface branch_predictor_btb_if #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
);
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_next_pc;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_uncond;
  logic             upd_pred_taken;
  logic [PC_W-1:0]  upd_pred_next_pc;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic             clear;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_uncond,
           upd_pred_taken, upd_pred_next_pc, clear,
    input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc,
           br_count, mispred_count
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_uncond,
           upd_pred_taken, upd_pred_next_pc, clear,
    output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc,
           br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up-counter used for the predictor's performance statistics.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters, trained from EX,
// plus mispredict detection and branch/mispredict statistics.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 64,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned CNT_W   = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_btb_if.slave bp
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam ctr_t        CtrMax  = ctr_max(CTR_W);
  localparam ctr_t        CtrWt   = ctr_wt(CTR_W);
  localparam ctr_t        CtrWnt  = ctr_wnt(CTR_W);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  tag_t             lk_tag, up_tag;
  btb_entry_t       lk_e;
  logic             up_hit;
  logic             mispredict;

  always_comb begin
    lk_idx = IDX_W'(pc_idx(MAX_PC_W'(bp.lookup_pc), IDX_W));
    lk_tag = pc_tag(MAX_PC_W'(bp.lookup_pc), IDX_W, TAG_W);
    up_idx = IDX_W'(pc_idx(MAX_PC_W'(bp.upd_pc), IDX_W));
    up_tag = pc_tag(MAX_PC_W'(bp.upd_pc), IDX_W, TAG_W);
    lk_e   = btb_q[lk_idx];
    up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);
  end

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  always_comb begin
    bp.pred_hit     = lk_e.valid && (lk_e.tag == lk_tag);
    bp.pred_taken   = bp.pred_hit && ctr_msb(lk_e.ctr, CTR_W);
    bp.pred_next_pc = bp.pred_taken ? PC_W'(lk_e.target) : bp.lookup_pc + PC_W'(4);
  end

  always_comb begin
    mispredict     = 1'b0;
    bp.redirect_pc = '0;
    if (bp.upd_valid) begin
      mispredict = (bp.upd_taken != bp.upd_pred_taken) ||
                   (bp.upd_taken && (bp.upd_target != bp.upd_pred_next_pc));
      bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + PC_W'(4);
    end
    bp.mispredict = mispredict;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CtrWnt};
      end
    end else if (bp.clear) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i].valid <= 1'b0;
        btb_q[i].ctr   <= CtrWnt;
      end
    end else if (bp.upd_valid) begin
      if (up_hit) begin
        btb_q[up_idx].ctr <= bp.upd_uncond ? CtrMax
                                           : ctr_next(btb_q[up_idx].ctr, bp.upd_taken, CTR_W);
        if (bp.upd_taken) btb_q[up_idx].target <= MAX_PC_W'(bp.upd_target);
      end else if (bp.upd_taken) begin
        btb_q[up_idx] <= '{valid:  1'b1,
                           tag:    up_tag,
                           target: MAX_PC_W'(bp.upd_target),
                           ctr:    bp.upd_uncond ? CtrMax : CtrWt};
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_br_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (bp.upd_valid),
    .count (bp.br_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_mispred_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict),
    .count (bp.mispred_count)
  );

endmodule
